trigger_count_snapshot: RTL and testbench
=========================================

# trigger_count_snapshot

Buffer-swap controller and readout stage for the per-channel self-trigger counters. On a buffer-switch request it flips the active memory buffer and clears every channel's trigger counter through the counters' init input. It snapshots the closed buffer's counts and streams them out one channel at a time over a valid/ready interface to the readout/header builder. It sits directly downstream of the per-channel trigger counters and drives their init.

## Interface
- NUM_CHAN, 5, number of channels / trigger counters
- CNT_W, 20, width of each trigger count
- CHAN_W, 3, width of channel index; must satisfy 2^CHAN_W >= NUM_CHAN
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- swap_req  in  1  single-cycle request to switch memory buffer
- swap_busy  out  1  high from the cycle after an accepted request until the readout of that swap completes
- swap_err  out  1  sticky; set when swap_req arrives while busy; cleared only by rst
- buf_sel  out  1  currently active memory buffer
- trig_cnt  in  NUM_CHAN*CNT_W  live counter values; channel k in bits [k*CNT_W +: CNT_W]
- cnt_init  out  NUM_CHAN  init pulse to all counters
- cnt_valid  out  1  output word valid
- cnt_ready  in  1  consumer accepts the word
- cnt_chan  out  CHAN_W  channel index of the current word
- cnt_buf  out  1  buffer the count belongs to (the buffer just closed)
- cnt_data  out  CNT_W  snapshot count

## Operation
- States: IDLE, INIT, SEND.
- IDLE: swap_req=1 causes three things at that edge:
  - go to INIT;
  - buf_sel toggles;
  - closed-buffer id (old buf_sel) latched for cnt_buf.
- INIT (exactly 1 cycle):
  - cnt_init = all ones;
  - at the end of the cycle, all NUM_CHAN counts from trig_cnt are latched into the snapshot registers;
  - channel index reset to 0;
  - go to SEND.
- SEND:
  - cnt_valid=1; cnt_data = snapshot[cnt_chan].
  - On cnt_valid & cnt_ready: if cnt_chan == NUM_CHAN-1, go to IDLE; otherwise increment cnt_chan.
  - cnt_chan, cnt_data and cnt_buf are held stable while valid & !ready.
- swap_busy = (state != IDLE).
- swap_req while not IDLE: ignored (no toggle, no init); swap_err set.
- Count coverage:
  - The snapshot contains every counter enable asserted up to and including the request cycle.
  - An enable coincident with the INIT cycle is discarded by the counter (init has priority), so it counts in neither buffer. This loss is accepted and documented for the trigger logic.
- Counts pass verbatim; counter wrap at 2^CNT_W is not detected here.

## Timing
- Reset values:
  - state IDLE; buf_sel 0; swap_busy 0; swap_err 0;
  - cnt_valid 0, cnt_chan 0, cnt_buf 0, cnt_data 0.
  - cnt_init is all ones in every cycle rst is high (counters start at zero after reset), and 0 in the first cycle after reset.
- rst mid-SEND: all state is dropped, no further words are emitted, buf_sel returns to 0.
- Latency, with swap_req at cycle t:
  - buf_sel new value visible at t+1;
  - cnt_init high during t+1 only;
  - first cnt_valid at t+2.
- Throughput: with cnt_ready held high, NUM_CHAN words on consecutive cycles t+2..t+NUM_CHAN+1, and swap_busy low from t+NUM_CHAN+2.
- A swap_req in the first cycle swap_busy is low is accepted (no dead cycle).
- A swap_req in the cycle of the final handshake is still while busy: it is rejected and sets swap_err.
- cnt_ready is ignored while cnt_valid=0.

## Structure
- Shared package trig_pkg holds:
  - NUM_CHAN, CNT_W, CHAN_W defaults;
  - the state encoding (IDLE=0, INIT=1, SEND=2).
- Single module, no sub-module. The snapshot register array and output mux are local. The trigger counters are instantiated beside this block at the channel level, not inside it.

## Test plan
- After reset: trig_cnt={5,4,3,2,1} (ch4..ch0); swap_req at t; ready always high. Expected:
  - cnt_init=5'h1F only at t+1;
  - buf_sel=1 from t+1;
  - words (chan,buf,data) = (0,0,1),(1,0,2),(2,0,3),(3,0,4),(4,0,5) at t+2..t+6;
  - swap_busy low at t+7.
- Backpressure: same stimulus, cnt_ready low for 3 cycles while ch2 is presented -> ch2 word held stable for 4 cycles, no word lost or repeated, 5 handshakes total.
- Second swap: after the first completes, swap_req with ch0 count 20'hFFFFF -> buf_sel=0, cnt_buf=1, ch0 data = 20'hFFFFF.
- Swap while busy: swap_req during SEND -> buf_sel unchanged, no extra cnt_init, swap_err=1 and stays 1 until rst.
- Reset mid-SEND after 2 handshakes -> cnt_valid=0 next cycle, buf_sel=0, cnt_init all ones during rst, no further words.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared sizing defaults and FSM state encoding for the trigger-count snapshot stage.
package trig_pkg;

  localparam int unsigned NUM_CHAN = 5;
  localparam int unsigned CNT_W    = 20;
  localparam int unsigned CHAN_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/trigger_count_snapshot.sv
// Buffer-swap controller: flips the active buffer, clears the trigger counters,
// snapshots the closed buffer's counts and streams them out over valid/ready.
module trigger_count_snapshot #(
  parameter int unsigned NUM_CHAN = trig_pkg::NUM_CHAN,
  parameter int unsigned CNT_W    = trig_pkg::CNT_W,
  parameter int unsigned CHAN_W   = trig_pkg::CHAN_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      swap_req,
  output logic                      swap_busy,
  output logic                      swap_err,
  output logic                      buf_sel,
  input  logic [NUM_CHAN*CNT_W-1:0] trig_cnt,
  output logic [NUM_CHAN-1:0]       cnt_init,
  output logic                      cnt_valid,
  input  logic                      cnt_ready,
  output logic [CHAN_W-1:0]         cnt_chan,
  output logic                      cnt_buf,
  output logic [CNT_W-1:0]          cnt_data
);
  import trig_pkg::*;

  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHAN - 1);

  state_t            state;
  logic [CNT_W-1:0]  snap [NUM_CHAN];
  logic [CHAN_W-1:0] next_chan;

  // Counters must read zero when reset releases, so init is driven straight from rst.
  assign cnt_init  = {NUM_CHAN{rst || (state == INIT)}};
  assign next_chan = cnt_chan + CHAN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      buf_sel   <= 1'b0;
      swap_busy <= 1'b0;
      swap_err  <= 1'b0;
      cnt_valid <= 1'b0;
      cnt_chan  <= '0;
      cnt_buf   <= 1'b0;
      cnt_data  <= '0;
      for (int k = 0; k < int'(NUM_CHAN); k++) snap[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (swap_req) begin
            state     <= INIT;
            buf_sel   <= ~buf_sel;
            cnt_buf   <= buf_sel;
            swap_busy <= 1'b1;
          end
        end
        INIT: begin
          // Counts sampled here include every enable up to the request cycle.
          for (int k = 0; k < int'(NUM_CHAN); k++) snap[k] <= trig_cnt[k*CNT_W +: CNT_W];
          cnt_chan  <= '0;
          cnt_data  <= trig_cnt[CNT_W-1:0];
          cnt_valid <= 1'b1;
          state     <= SEND;
          if (swap_req) swap_err <= 1'b1;
        end
        SEND: begin
          if (swap_req) swap_err <= 1'b1;
          if (cnt_ready) begin
            if (cnt_chan == LAST_CHAN) begin
              state     <= IDLE;
              cnt_valid <= 1'b0;
              swap_busy <= 1'b0;
            end else begin
              cnt_chan <= next_chan;
              cnt_data <= snap[next_chan];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_count_snapshot.sv
// Directed table-driven bench for trigger_count_snapshot.
module tb_trigger_count_snapshot;

  logic         clk = 1'b0;
  logic         rst;
  logic         swap_req;
  logic         swap_busy;
  logic         swap_err;
  logic         buf_sel;
  logic [99:0]  trig_cnt;
  logic [4:0]   cnt_init;
  logic         cnt_valid;
  logic         cnt_ready;
  logic [2:0]   cnt_chan;
  logic         cnt_buf;
  logic [19:0]  cnt_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trigger_count_snapshot dut (
    .clk       (clk),
    .rst       (rst),
    .swap_req  (swap_req),
    .swap_busy (swap_busy),
    .swap_err  (swap_err),
    .buf_sel   (buf_sel),
    .trig_cnt  (trig_cnt),
    .cnt_init  (cnt_init),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .cnt_chan  (cnt_chan),
    .cnt_buf   (cnt_buf),
    .cnt_data  (cnt_data)
  );

  typedef struct {
    logic        rst, req, rdy;
    logic [99:0] trig;
    logic [4:0]  init;
    logic        busy, valid;
    logic [2:0]  chan;
    logic        cbuf;
    logic [19:0] data;
    logic        bsel, err;
    logic        full;  // also compare chan/buf/data
  } vec_t;

  vec_t vecs[$];

  function automatic logic [99:0] pk(input logic [19:0] c4, c3, c2, c1, c0);
    return {c4, c3, c2, c1, c0};
  endfunction

  function automatic vec_t mk(input logic r, q, y, input logic [99:0] t, input logic [4:0] i,
                              input logic b, vl, input logic [2:0] c, input logic cb,
                              input logic [19:0] d, input logic bs, e, f);
    vec_t v;
    v.rst = r; v.req = q; v.rdy = y; v.trig = t; v.init = i; v.busy = b; v.valid = vl;
    v.chan = c; v.cbuf = cb; v.data = d; v.bsel = bs; v.err = e; v.full = f;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [99:0] t1, t2, t3;
    t1 = pk(20'd5, 20'd4, 20'd3, 20'd2, 20'd1);
    t2 = pk(20'd5, 20'd4, 20'd3, 20'd2, 20'hFFFFF);
    t3 = pk(20'd50, 20'd40, 20'd30, 20'd20, 20'd10);

    //                   r  q  y  trig init   bsy vld ch cb data        bs er full
    // reset and first swap, ready held high
    vecs.push_back(mk(1, 0, 1, t1, 5'h1F, 0, 0, 0, 0, 20'd0,     0, 0, 1));
    vecs.push_back(mk(1, 0, 1, t1, 5'h1F, 0, 0, 0, 0, 20'd0,     0, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 0, 0, 0, 0, 20'd0,     0, 0, 1));
    vecs.push_back(mk(0, 1, 1, t1, 5'h1F, 1, 0, 0, 0, 20'd0,     1, 0, 0));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 0, 0, 20'd1,     1, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 1, 0, 20'd2,     1, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 2, 0, 20'd3,     1, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 3, 0, 20'd4,     1, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 4, 0, 20'd5,     1, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 0, 0, 0, 0, 20'd0,     1, 0, 0));
    // second swap in the first non-busy cycle; counts change during INIT and must be taken then
    vecs.push_back(mk(0, 1, 1, t1, 5'h1F, 1, 0, 0, 0, 20'd0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 1, t2, 5'h00, 1, 1, 0, 1, 20'hFFFFF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, t2, 5'h00, 1, 1, 1, 1, 20'd2,     0, 0, 1));
    vecs.push_back(mk(0, 0, 1, t2, 5'h00, 1, 1, 2, 1, 20'd3,     0, 0, 1));
    vecs.push_back(mk(0, 0, 1, t2, 5'h00, 1, 1, 3, 1, 20'd4,     0, 0, 1));
    vecs.push_back(mk(0, 0, 1, t2, 5'h00, 1, 1, 4, 1, 20'd5,     0, 0, 1));
    vecs.push_back(mk(0, 0, 1, t2, 5'h00, 0, 0, 0, 0, 20'd0,     0, 0, 0));
    // backpressure on ch2, then swap_req on the final handshake
    vecs.push_back(mk(0, 1, 1, t1, 5'h1F, 1, 0, 0, 0, 20'd0,     1, 0, 0));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 0, 0, 20'd1,     1, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 1, 0, 20'd2,     1, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 2, 0, 20'd3,     1, 0, 1));
    vecs.push_back(mk(0, 0, 0, t1, 5'h00, 1, 1, 2, 0, 20'd3,     1, 0, 1));
    vecs.push_back(mk(0, 0, 0, t1, 5'h00, 1, 1, 2, 0, 20'd3,     1, 0, 1));
    vecs.push_back(mk(0, 0, 0, t1, 5'h00, 1, 1, 2, 0, 20'd3,     1, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 3, 0, 20'd4,     1, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 4, 0, 20'd5,     1, 0, 1));
    vecs.push_back(mk(0, 1, 1, t1, 5'h00, 0, 0, 0, 0, 20'd0,     1, 1, 0));
    // swap with ready low through INIT, then swap_req during SEND is rejected
    vecs.push_back(mk(0, 1, 0, t3, 5'h1F, 1, 0, 0, 0, 20'd0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 0, t3, 5'h00, 1, 1, 0, 1, 20'd10,    0, 1, 1));
    vecs.push_back(mk(0, 1, 1, t3, 5'h00, 1, 1, 1, 1, 20'd20,    0, 1, 1));
    vecs.push_back(mk(0, 0, 1, t3, 5'h00, 1, 1, 2, 1, 20'd30,    0, 1, 1));
    vecs.push_back(mk(0, 0, 1, t3, 5'h00, 1, 1, 3, 1, 20'd40,    0, 1, 1));
    vecs.push_back(mk(0, 0, 1, t3, 5'h00, 1, 1, 4, 1, 20'd50,    0, 1, 1));
    vecs.push_back(mk(0, 0, 1, t3, 5'h00, 0, 0, 0, 0, 20'd0,     0, 1, 0));
    // reset after two handshakes
    vecs.push_back(mk(0, 1, 1, t1, 5'h1F, 1, 0, 0, 0, 20'd0,     1, 1, 0));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 0, 0, 20'd1,     1, 1, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 1, 0, 20'd2,     1, 1, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 1, 1, 2, 0, 20'd3,     1, 1, 1));
    vecs.push_back(mk(1, 0, 1, t1, 5'h1F, 0, 0, 0, 0, 20'd0,     0, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 0, 0, 0, 0, 20'd0,     0, 0, 1));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 0, 0, 0, 0, 20'd0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 1, t1, 5'h00, 0, 0, 0, 0, 20'd0,     0, 0, 0));

    rst = 1'b1; swap_req = 1'b0; cnt_ready = 1'b1; trig_cnt = t1;
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      swap_req  = vecs[i].req;
      cnt_ready = vecs[i].rdy;
      trig_cnt  = vecs[i].trig;
      @(negedge clk);
      check("cnt_init",  i, 32'(cnt_init),  32'(vecs[i].init));
      check("swap_busy", i, 32'(swap_busy), 32'(vecs[i].busy));
      check("cnt_valid", i, 32'(cnt_valid), 32'(vecs[i].valid));
      check("buf_sel",   i, 32'(buf_sel),   32'(vecs[i].bsel));
      check("swap_err",  i, 32'(swap_err),  32'(vecs[i].err));
      if (vecs[i].full) begin
        check("cnt_chan", i, 32'(cnt_chan), 32'(vecs[i].chan));
        check("cnt_buf",  i, 32'(cnt_buf),  32'(vecs[i].cbuf));
        check("cnt_data", i, 32'(cnt_data), 32'(vecs[i].data));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
